fp_normalize_round: RTL and testbench

//  Back end of the floating-point adder. Takes the unnormalised sum produced after

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_round_ne.sv | 46 ++++
 rtl/fp_normalize_round.sv | 142 ++++++++++++++
 tb/tb_fp_normalize_round.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, FSM state encoding and packed result type for the FP adder back end.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned GRS_W  = 7;
  localparam int unsigned W      = FRAC_W + GRS_W + 2;
  localparam int unsigned BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t NORM  = 2'd1;
  localparam state_t ROUND = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_round_ne.sv
// Combinational round-to-nearest-even on a normalised (or denormal) extended fraction.
module fp_round_ne
  import fp_pkg::*;
(
  input  logic [W-1:0]      frac_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              ovf,
  output logic              inexact
);

  logic                lsb;
  logic                guard;
  logic                sticky;
  logic                inc;
  logic [FRAC_W+1:0]   mant_sum;
  logic [EXP_W:0]      exp_sum;

  assign lsb    = frac_in[GRS_W];
  assign guard  = frac_in[GRS_W-1];
  assign sticky = |frac_in[GRS_W-2:0];
  assign inc    = guard & (sticky | lsb);

  // Carry bit is always clear here, so the 25-bit sum cannot wrap.
  assign mant_sum = frac_in[W-1:GRS_W] + (FRAC_W+2)'(inc);

  always_comb begin
    exp_sum  = {1'b0, exp_in};
    frac_out = mant_sum[FRAC_W-1:0];
    if (mant_sum[FRAC_W+1]) begin
      exp_sum  = exp_sum + (EXP_W+1)'(1);
      frac_out = mant_sum[FRAC_W:1];
    end else if ((exp_in == '0) && mant_sum[FRAC_W]) begin
      // Denormal rounded up into the smallest normal.
      exp_sum = (EXP_W+1)'(1);
    end
    ovf     = (exp_sum >= {1'b0, EXP_MAX});
    exp_out = ovf ? EXP_MAX : exp_sum[EXP_W-1:0];
    if (ovf) begin
      frac_out = '0;
    end
    inexact = guard | sticky;
  end

endmodule

// File: rtl/fp_normalize_round.sv
// FP adder back end: iterative normalise (one shift per cycle), RNE round, IEEE-754 single pack.
module fp_normalize_round
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [W-1:0]     in_frac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_inexact
);

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [W-1:0]     frac_q, frac_d;
  fp32_t            result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             inexact_q, inexact_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  logic [FRAC_W-1:0] rnd_frac;
  logic [EXP_W-1:0]  rnd_exp;
  logic              rnd_ovf;
  logic              rnd_inexact;

  fp_round_ne u_round (
    .frac_in  (frac_q),
    .exp_in   (exp_q),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .ovf      (rnd_ovf),
    .inexact  (rnd_inexact)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      frac_q    <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      frac_q    <= frac_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      inexact_q <= inexact_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    frac_d    = frac_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    inexact_d = inexact_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          frac_d  = in_frac;
          state_d = NORM;
        end
      end
      NORM: begin
        if (frac_q == '0) begin
          exp_d         = '0;
          result_d.sign = sign_q;
          result_d.exp  = '0;
          result_d.frac = '0;
          zero_d        = 1'b1;
          ovf_d         = 1'b0;
          inexact_d     = 1'b0;
          state_d       = DONE;
        end else if (frac_q[W-1]) begin
          frac_d  = {1'b0, frac_q[W-1:2], |frac_q[1:0]};
          exp_d   = exp_q + EXP_W'(1);
          state_d = ROUND;
        end else if (frac_q[W-2]) begin
          state_d = ROUND;
        end else if (exp_q <= EXP_W'(1)) begin
          exp_d   = '0;
          state_d = ROUND;
        end else begin
          frac_d = {frac_q[W-2:0], 1'b0};
          exp_d  = exp_q - EXP_W'(1);
        end
      end
      ROUND: begin
        result_d.sign = sign_q;
        result_d.exp  = rnd_exp;
        result_d.frac = rnd_frac;
        zero_d        = (rnd_exp == '0) && (rnd_frac == '0);
        ovf_d         = rnd_ovf;
        inexact_d     = rnd_inexact;
        state_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  assign in_ready    = ready_q;
  assign out_valid   = valid_q;
  assign out_result  = result_q;
  assign out_zero    = zero_q;
  assign out_ovf     = ovf_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed scoreboard bench for fp_normalize_round: results, flags, latency, backpressure, reset.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [31:0] in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic        out_inexact;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        inexact;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_normalize_round dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_frac     (in_frac),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Latency counts clock edges from the accepting edge to the first edge that sees out_valid.
  task automatic send(input logic s, input logic [7:0] e, input logic [31:0] f,
                      input logic [31:0] res, input logic z, input logic o,
                      input logic ix, input int lat);
    exp_t x;
    int   cyc;
    x.result  = res;
    x.zero    = z;
    x.ovf     = o;
    x.inexact = ix;
    x.lat     = 8'(lat);
    sb.push_back(x);
    in_sign  = s;
    in_exp   = e;
    in_frac  = f;
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_exp   = 8'h00;
    in_frac  = 32'h0;
    cyc = 1;
    while (!out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    x = sb.pop_front();
    chk("result",    out_result,          x.result);
    chk("zero",      32'(out_zero),       32'(x.zero));
    chk("ovf",       32'(out_ovf),        32'(x.ovf));
    chk("inexact",   32'(out_inexact),    32'(x.inexact));
    chk("latency",   32'(cyc),            32'(x.lat));
    chk("busy_ready", 32'(in_ready),      32'd0);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready),  32'd1);
  endtask

  initial begin
    int seen;
    logic [31:0] held;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h00;
    in_frac   = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid",   32'(out_valid),   32'd0);
    chk("rst_ready",   32'(in_ready),    32'd1);
    chk("rst_result",  out_result,       32'h0);
    chk("rst_zero",    32'(out_zero),    32'd0);
    chk("rst_ovf",     32'(out_ovf),     32'd0);
    chk("rst_inexact", 32'(out_inexact), 32'd0);

    // 1.0 + 1.0: carry normalised by a right shift
    send(1'b0, 8'd127, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 3);  drain();
    // heavy cancellation: 23 left shifts
    send(1'b0, 8'd127, 32'h0000_0080, 32'h3400_0000, 1'b0, 1'b0, 1'b0, 26); drain();
    // ties: odd LSB rounds up, even LSB stays
    send(1'b0, 8'd127, 32'h4000_00C0, 32'h3F80_0002, 1'b0, 1'b0, 1'b1, 3);  drain();
    send(1'b0, 8'd127, 32'h4000_0040, 32'h3F80_0000, 1'b0, 1'b0, 1'b1, 3);  drain();
    // rounding carry-out renormalises
    send(1'b0, 8'd127, 32'h7FFF_FFC0, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 3);  drain();
    // overflow from carry shift and from rounding
    send(1'b1, 8'd254, 32'h8000_0000, 32'hFF80_0000, 1'b0, 1'b1, 1'b0, 3);  drain();
    send(1'b0, 8'd254, 32'h7FFF_FFC0, 32'h7F80_0000, 1'b0, 1'b1, 1'b1, 3);  drain();
    // zeros keep the sign and skip rounding
    send(1'b0, 8'd100, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2);  drain();
    send(1'b1, 8'd100, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2);  drain();
    // denormal outputs, including one reached after left shifts and one rounding up to normal
    send(1'b0, 8'd1,   32'h2000_0000, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 3);  drain();
    send(1'b0, 8'd3,   32'h0800_0000, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 5);  drain();
    send(1'b0, 8'd1,   32'h3FFF_FFC0, 32'h0080_0000, 1'b0, 1'b0, 1'b1, 3);  drain();
    // bit dropped by the right shift lands in sticky
    send(1'b0, 8'd127, 32'h8000_0001, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 3);  drain();
    send(1'b1, 8'd130, 32'h1000_0000, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 5);  drain();

    // backpressure: result held stable while out_ready is low
    out_ready = 1'b0;
    send(1'b0, 8'd127, 32'h4000_00C0, 32'h3F80_0002, 1'b0, 1'b0, 1'b1, 3);
    held = out_result;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_valid",  32'(out_valid), 32'd1);
      chk("hold_result", out_result,     held);
      chk("hold_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    drain();

    // reset in the middle of a long normalisation discards the work
    in_sign  = 1'b0;
    in_exp   = 8'd127;
    in_frac  = 32'h0000_0080;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_valid",  32'(out_valid), 32'd0);
    chk("midrst_ready",  32'(in_ready),  32'd1);
    chk("midrst_result", out_result,     32'h0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    send(1'b0, 8'd127, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 3);  drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
